// File: rtl/spikes_pingpong_store_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spikes_pingpong_store_pkg
// Description : Shared definitions for the spike-line ping-pong store:
//               frame FSM state encoding and default geometry (line width
//               derived from systolic array size and time steps, frame depth).
// Revision    : 1.0 - initial release
// ============================================================================
package spikes_pingpong_store_pkg;

    localparam int SYSTOLIC_UNIT_NUM = 16;
    localparam int TIME_STEPS        = 4;
    localparam int DEFAULT_DATA_W    = 2 * SYSTOLIC_UNIT_NUM * TIME_STEPS;
    localparam int DEFAULT_DEPTH     = 768;

    // S_FILL : no readable frame
    // S_READ : one frame readable, the other bank filling
    // S_FULL : both banks hold frames, writers stalled
    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_READ = 2'd1,
        S_FULL = 2'd2
    } state_t;

endpackage : spikes_pingpong_store_pkg
`default_nettype wire

// File: rtl/spikes_pingpong_store_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : spikes_sdp_ram
// Description : Simple dual-port RAM. Port A write-only, port B read-only
//               with a registered output (1-cycle latency). Only the output
//               register is reset; the array contents are not.
// Ports       : clk, rst_n (async, active-low, output register only)
//               i_we/i_waddr/i_wdata  - write port
//               i_re/i_raddr/o_rdata  - read port
// Revision    : 1.0 - initial release
// ============================================================================
module spikes_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int c_WORDS = 2 ** AW;

    logic [WIDTH-1:0] r_mem [c_WORDS];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : spikes_sdp_ram
`default_nettype wire

// File: rtl/spikes_pingpong_store.sv
`default_nettype none
// ============================================================================
// Module      : spikes_pingpong_store
// Description : N-channel spike-line frame buffer between the LIF stage and
//               the attention stage. Each channel owns a dual-port RAM; with
//               SPIKES_PINGPONG_EN defined, two banks per channel form a
//               ping-pong pair so a new frame fills while the current one is
//               read. Frames are handed over with an explicit handshake
//               (o_frame_ready / i_frame_release).
// Config      : SPIKES_PINGPONG_EN - defined: two banks, FILL/READ/FULL FSM.
//                                    undefined: single bank, FILL/FULL only.
// Ports       : s_clk, s_rst_n (async, active-low)
//               i_wr_data/i_wr_valid/o_wr_ready  - per-channel line writes
//               i_rd_addr/i_rd_en/o_rd_data/o_rd_valid - per-channel reads
//               o_frame_ready, i_frame_release   - frame handshake
//               o_wr_bank, o_rd_bank              - bank selection status
//               o_overflow                        - sticky dropped-write flag
// Revision    : 1.0 - initial release
// ============================================================================
module spikes_pingpong_store
    import spikes_pingpong_store_pkg::*;
#(
    parameter int CH_NUM = 3,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = 10
) (
    input  logic                     s_clk,
    input  logic                     s_rst_n,
    input  logic [CH_NUM*DATA_W-1:0] i_wr_data,
    input  logic [CH_NUM-1:0]        i_wr_valid,
    output logic [CH_NUM-1:0]        o_wr_ready,
    input  logic [CH_NUM*ADDR_W-1:0] i_rd_addr,
    input  logic [CH_NUM-1:0]        i_rd_en,
    output logic [CH_NUM*DATA_W-1:0] o_rd_data,
    output logic [CH_NUM-1:0]        o_rd_valid,
    output logic                     o_frame_ready,
    input  logic                     i_frame_release,
    output logic                     o_wr_bank,
    output logic                     o_rd_bank,
    output logic                     o_overflow
);

    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
`ifdef SPIKES_PINGPONG_EN
    localparam int c_RAM_AW = ADDR_W + 1;
`else
    localparam int c_RAM_AW = ADDR_W;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_clear;
    logic [CH_NUM-1:0]   w_ch_done;
    logic [CH_NUM-1:0]   w_wr_drop;
    logic                w_fill_done;
    logic                r_overflow;
    logic [CH_NUM-1:0]   r_rd_valid;

    // ------------------------------------------------------------------
    // Bank pointer: only the write bank is stored, read bank is its inverse
    // ------------------------------------------------------------------
`ifdef SPIKES_PINGPONG_EN
    logic r_wr_bank;
    logic w_swap;

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_wr_bank <= 1'b0;
        end else if (w_swap) begin
            r_wr_bank <= ~r_wr_bank;
        end
    end

    assign o_wr_bank = r_wr_bank;
    assign o_rd_bank = ~r_wr_bank;
`else
    assign o_wr_bank = 1'b0;
    assign o_rd_bank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Per-channel write counters and RAMs
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [ADDR_W:0]       r_wr_cnt;
        logic [ADDR_W:0]       w_cnt_nxt;
        logic                  w_wr_fire;
        logic [c_RAM_AW-1:0]   w_waddr;
        logic [c_RAM_AW-1:0]   w_raddr;

        // A full channel holds off until the next swap/clear; this gating
        // is also what keeps the counter from ever passing DEPTH.
        assign o_wr_ready[c] = (r_wr_cnt != c_DEPTH_CNT);
        assign w_wr_fire     = i_wr_valid[c] & o_wr_ready[c];
        assign w_wr_drop[c]  = i_wr_valid[c] & ~o_wr_ready[c];
        assign w_cnt_nxt     = r_wr_cnt + {{ADDR_W{1'b0}}, w_wr_fire};
        // Based on the next count so the frame completes on the same edge
        // as its last line.
        assign w_ch_done[c]  = (w_cnt_nxt == c_DEPTH_CNT);

`ifdef SPIKES_PINGPONG_EN
        assign w_waddr = {r_wr_bank, r_wr_cnt[ADDR_W-1:0]};
        assign w_raddr = {~r_wr_bank, i_rd_addr[c*ADDR_W +: ADDR_W]};
`else
        assign w_waddr = r_wr_cnt[ADDR_W-1:0];
        assign w_raddr = i_rd_addr[c*ADDR_W +: ADDR_W];
`endif

        always_ff @(posedge s_clk or negedge s_rst_n) begin
            if (!s_rst_n) begin
                r_wr_cnt <= '0;
            end else if (w_clear) begin
                r_wr_cnt <= '0;
            end else begin
                r_wr_cnt <= w_cnt_nxt;
            end
        end

        spikes_sdp_ram #(
            .WIDTH (DATA_W),
            .AW    (c_RAM_AW)
        ) u_ram (
            .clk     (s_clk),
            .rst_n   (s_rst_n),
            .i_we    (w_wr_fire),
            .i_waddr (w_waddr),
            .i_wdata (i_wr_data[c*DATA_W +: DATA_W]),
            .i_re    (i_rd_en[c]),
            .i_raddr (w_raddr),
            .o_rdata (o_rd_data[c*DATA_W +: DATA_W])
        );
    end

    assign w_fill_done = &w_ch_done;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
`ifdef SPIKES_PINGPONG_EN
        w_swap      = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_fill_done) begin
                    w_swap      = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (i_frame_release && w_fill_done) begin
                    // Consumer done and new frame complete together:
                    // hand the new frame straight over.
                    w_swap  = 1'b1;
                    w_clear = 1'b1;
                end else if (i_frame_release) begin
                    w_state_nxt = S_FILL;
                end else if (w_fill_done) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (i_frame_release) begin
                    w_swap      = 1'b1;
                    w_clear     = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
`else
        case (r_state)
            S_FILL: begin
                if (w_fill_done) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (i_frame_release) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
`endif
    end

    assign o_frame_ready = (r_state != S_FILL);

    // ------------------------------------------------------------------
    // Read valid and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_rd_valid <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en & {CH_NUM{o_frame_ready}};
            r_overflow <= r_overflow | (|w_wr_drop);
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_overflow = r_overflow;

endmodule : spikes_pingpong_store
`default_nettype wire

// File: tb/tb_spikes_pingpong_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_spikes_pingpong_store
// Description : Directed self-checking bench for spikes_pingpong_store with
//               CH_NUM=3, DATA_W=8, DEPTH=4, ADDR_W=2. Covers the ping-pong
//               build when SPIKES_PINGPONG_EN is defined, otherwise the
//               single-bank build. Read data is checked through a queue of
//               expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spikes_pingpong_store;

    localparam int CH = 3;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AW = 2;
`ifdef SPIKES_PINGPONG_EN
    localparam logic RST_RD_BANK = 1'b1;
`else
    localparam logic RST_RD_BANK = 1'b0;
`endif

    logic              s_clk = 1'b0;
    logic              s_rst_n = 1'b0;
    logic [CH*DW-1:0]  i_wr_data = '0;
    logic [CH-1:0]     i_wr_valid = '0;
    logic [CH-1:0]     o_wr_ready;
    logic [CH*AW-1:0]  i_rd_addr = '0;
    logic [CH-1:0]     i_rd_en = '0;
    logic [CH*DW-1:0]  o_rd_data;
    logic [CH-1:0]     o_rd_valid;
    logic              o_frame_ready;
    logic              i_frame_release = 1'b0;
    logic              o_wr_bank;
    logic              o_rd_bank;
    logic              o_overflow;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];

    always #5 s_clk = ~s_clk;

    spikes_pingpong_store #(
        .CH_NUM (CH),
        .DATA_W (DW),
        .DEPTH  (DP),
        .ADDR_W (AW)
    ) dut (
        .s_clk           (s_clk),
        .s_rst_n         (s_rst_n),
        .i_wr_data       (i_wr_data),
        .i_wr_valid      (i_wr_valid),
        .o_wr_ready      (o_wr_ready),
        .i_rd_addr       (i_rd_addr),
        .i_rd_en         (i_rd_en),
        .o_rd_data       (o_rd_data),
        .o_rd_valid      (o_rd_valid),
        .o_frame_ready   (o_frame_ready),
        .i_frame_release (i_frame_release),
        .o_wr_bank       (o_wr_bank),
        .o_rd_bank       (o_rd_bank),
        .o_overflow      (o_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    // Write n consecutive lines base..base+n-1 on every channel.
    task automatic wr_all(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            i_wr_valid = '1;
            i_wr_data  = {3{base + 8'(i)}};
            tick();
        end
        i_wr_valid = '0;
    endtask

    task automatic wr_ch(input int ch, input logic [7:0] d);
        i_wr_valid     = '0;
        i_wr_valid[ch] = 1'b1;
        i_wr_data[ch*DW +: DW] = d;
        tick();
        i_wr_valid = '0;
    endtask

    // Issue a read, expect valid and the queued data one cycle later.
    task automatic rd(input int ch, input int addr, input logic [7:0] exp, input logic rel);
        logic [7:0] e;
        i_rd_en     = '0;
        i_rd_en[ch] = 1'b1;
        i_rd_addr[ch*AW +: AW] = AW'(addr);
        i_frame_release = rel;
        exp_q.push_back(exp);
        tick();
        i_rd_en = '0;
        i_frame_release = 1'b0;
        e = exp_q.pop_front();
        check("rd_valid", 32'(o_rd_valid[ch]), 32'd1);
        check("rd_data", 32'(o_rd_data[ch*DW +: DW]), 32'(e));
    endtask

    task automatic release_frame();
        i_frame_release = 1'b1;
        tick();
        i_frame_release = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_wr_bank", 32'(o_wr_bank), 32'd0);
        check("rst_rd_bank", 32'(o_rd_bank), 32'(RST_RD_BANK));
        check("rst_frame_ready", 32'(o_frame_ready), 32'd0);
        check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_rd_data", 32'(o_rd_data), 32'd0);
        check("rst_wr_ready", 32'(o_wr_ready), 32'h7);
    endtask

    initial begin
        tick();
        tick();
        check_reset_vals();
        s_rst_n = 1'b1;
        tick();

`ifdef SPIKES_PINGPONG_EN
        // Partial frame: ch0/ch1 complete, ch2 one short
        wr_all(8'h10, 3);
        wr_ch(0, 8'h13);
        wr_ch(1, 8'h13);
        check("partial_frame_ready", 32'(o_frame_ready), 32'd0);
        check("partial_wr_ready", 32'(o_wr_ready), 32'h4);
        wr_ch(0, 8'h99);
        check("overflow_set", 32'(o_overflow), 32'd1);
        wr_ch(2, 8'h13);
        check("frameA_ready", 32'(o_frame_ready), 32'd1);
        check("frameA_rd_bank", 32'(o_rd_bank), 32'd0);
        check("frameA_wr_bank", 32'(o_wr_bank), 32'd1);
        for (int a = 0; a < DP; a++) rd(1, a, 8'h10 + 8'(a), 1'b0);
        rd(0, 3, 8'h13, 1'b0);   // dropped 0x99 must not have landed

        // Frame B fills the other bank -> FULL
        wr_all(8'h20, 4);
        check("full_wr_ready", 32'(o_wr_ready), 32'h0);
        check("full_frame_ready", 32'(o_frame_ready), 32'd1);
        check("full_rd_bank", 32'(o_rd_bank), 32'd0);
        // Read issued on the release edge still sees frame A
        rd(0, 0, 8'h10, 1'b1);
        check("rel_rd_bank", 32'(o_rd_bank), 32'd1);
        check("rel_wr_ready", 32'(o_wr_ready), 32'h7);
        rd(1, 2, 8'h22, 1'b0);

        // Frame C: last write coincides with release
        for (int i = 0; i < 3; i++) begin
            i_wr_valid = '1;
            i_wr_data  = {3{8'h30 + 8'(i)}};
            tick();
            check("C_frame_ready_hold", 32'(o_frame_ready), 32'd1);
        end
        i_wr_valid = '1;
        i_wr_data  = {3{8'h33}};
        i_frame_release = 1'b1;
        tick();
        i_wr_valid = '0;
        i_frame_release = 1'b0;
        check("C_frame_ready", 32'(o_frame_ready), 32'd1);
        check("C_rd_bank", 32'(o_rd_bank), 32'd0);
        check("C_wr_ready", 32'(o_wr_ready), 32'h7);
        rd(0, 3, 8'h33, 1'b0);
        rd(2, 0, 8'h30, 1'b0);
        // Counters restarted at 0: three lines leave room, fourth fills
        wr_all(8'h40, 3);
        check("D_wr_ready_3", 32'(o_wr_ready), 32'h7);
        wr_all(8'h43, 1);
        check("D_wr_ready_4", 32'(o_wr_ready), 32'h0);

        // Release twice: FULL -> READ -> FILL
        release_frame();
        check("D_rd_bank", 32'(o_rd_bank), 32'd1);
        release_frame();
        check("fill_frame_ready", 32'(o_frame_ready), 32'd0);
        i_rd_en = 3'b001;
        i_rd_addr = '0;
        tick();
        i_rd_en = '0;
        check("no_valid_in_fill", 32'(o_rd_valid), 32'd0);

        // Asynchronous reset mid-fill
        wr_all(8'h50, 2);
        #2 s_rst_n = 1'b0;
        #1;
        check_reset_vals();
        tick();
        s_rst_n = 1'b1;
        tick();
        wr_all(8'h50, 4);
        check("post_rst_frame_ready", 32'(o_frame_ready), 32'd1);
        check("post_rst_rd_bank", 32'(o_rd_bank), 32'd0);
        rd(2, 3, 8'h53, 1'b0);
`else
        wr_all(8'h10, 2);
        check("sb_partial_ready", 32'(o_frame_ready), 32'd0);
        check("sb_partial_wr_ready", 32'(o_wr_ready), 32'h7);
        wr_all(8'h12, 2);
        check("sb_frame_ready", 32'(o_frame_ready), 32'd1);
        check("sb_wr_ready", 32'(o_wr_ready), 32'h0);
        check("sb_wr_bank", 32'(o_wr_bank), 32'd0);
        check("sb_rd_bank", 32'(o_rd_bank), 32'd0);
        rd(1, 2, 8'h12, 1'b0);
        wr_ch(0, 8'h99);
        check("sb_overflow", 32'(o_overflow), 32'd1);
        rd(0, 3, 8'h13, 1'b0);
        release_frame();
        check("sb_rel_frame_ready", 32'(o_frame_ready), 32'd0);
        check("sb_rel_wr_ready", 32'(o_wr_ready), 32'h7);
        wr_all(8'h60, 4);
        check("sb_refill_ready", 32'(o_frame_ready), 32'd1);
        rd(1, 2, 8'h62, 1'b0);
        rd(2, 0, 8'h60, 1'b0);
        wr_all(8'h70, 2);
        #2 s_rst_n = 1'b0;
        #1;
        check_reset_vals();
        tick();
        s_rst_n = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_spikes_pingpong_store
`default_nettype wire
